// File: rtl/pss_generator_if.sv
// rtl/pss_generator_if.sv - Sample stream interface between the PSS generator and its consumer
interface pss_generator_if #(
    parameter int OUT_DW = 32
) ();
    logic [OUT_DW-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/pss_generator.sv
// rtl/pss_generator.sv - NR PSS d(n) generator streaming BPSK samples; optional PSS_GEN_CONTINUOUS_EN
module pss_generator #(
    parameter int OUT_DW    = 32,
    parameter int AMPLITUDE = 8192
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       N_id_2_i,
    input  logic             start_i,
    output logic             busy_o,
    pss_generator_if.master  m_axis_out
);
    localparam int              HW        = OUT_DW / 2;
    localparam logic [6:0]      LFSR_INIT = 7'b1110110;
    localparam logic [6:0]      LAST_IDX  = 7'd126;
    localparam logic [HW-1:0]   AMP_POS   = HW'(AMPLITUDE);
    localparam logic [HW-1:0]   AMP_NEG   = HW'(-AMPLITUDE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEEK   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [6:0] lfsr_q;
    logic [6:0] seek_cnt_q;
    logic [6:0] sample_cnt_q;
    logic       start_ok;
    logic       handshake;
    logic       at_last;
    logic [6:0] lfsr_step;

    assign start_ok  = start_i && (N_id_2_i != 2'd3);
    assign handshake = (state_q == S_STREAM) && m_axis_out.tready;
    assign at_last   = (sample_cnt_q == LAST_IDX);
    assign lfsr_step = {lfsr_q[4] ^ lfsr_q[0], lfsr_q[6:1]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (N_id_2_i == 2'd0) ? S_STREAM : S_SEEK;
                end
            end
            S_SEEK: begin
                if (seek_cnt_q == 7'd0) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (handshake && at_last) begin
`ifdef PSS_GEN_CONTINUOUS_EN
                    state_d = start_i ? S_STREAM : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The seek load encodes 43*N_id_2-1 so SEEK performs exactly 43*N_id_2 LFSR steps.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q       <= LFSR_INIT;
            seek_cnt_q   <= 7'd0;
            sample_cnt_q <= 7'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    lfsr_q       <= LFSR_INIT;
                    sample_cnt_q <= 7'd0;
                    if (start_ok) begin
                        seek_cnt_q <= (N_id_2_i == 2'd1) ? 7'd42 : 7'd85;
                    end
                end
                S_SEEK: begin
                    lfsr_q <= lfsr_step;
                    if (seek_cnt_q != 7'd0) begin
                        seek_cnt_q <= seek_cnt_q - 7'd1;
                    end
                end
                S_STREAM: begin
                    if (handshake) begin
                        if (at_last) begin
                            sample_cnt_q <= 7'd0;
                            // A continuous wrap keeps stepping; period 127 lands back on the sequence start.
                            lfsr_q <= (state_d == S_IDLE) ? LFSR_INIT : lfsr_step;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 7'd1;
                            lfsr_q       <= lfsr_step;
                        end
                    end
                end
                default: begin
                    lfsr_q       <= LFSR_INIT;
                    sample_cnt_q <= 7'd0;
                    seek_cnt_q   <= 7'd0;
                end
            endcase
        end
    end

    always_comb begin
        busy_o            = (state_q != S_IDLE);
        m_axis_out.tvalid = (state_q == S_STREAM);
        m_axis_out.tlast  = (state_q == S_STREAM) && at_last;
        m_axis_out.tdata  = '0;
        if (state_q == S_STREAM) begin
            m_axis_out.tdata = {{HW{1'b0}}, (lfsr_q[0] ? AMP_NEG : AMP_POS)};
        end
    end
endmodule
